alu_seq: RTL
============

# alu_seq

Sequencing controller for the 16-bit ALU result path. It accepts one operation at a time over a valid/ready handshake and issues it to the logic, shifter or add/sub unit. It drives the 2-bit result-mux select, waits for the unit, captures the mux output into a result register and presents it downstream over a second valid/ready handshake. It sits between the instruction decode stage and the ALU units and owns the result-mux select.

## Interface
- SHIFT_TIMEOUT, 32: maximum WAIT cycles for shift_done before the op is aborted with an error (legal range 2..255).
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- op_valid  in  1  operation request.
- op_ready  out  1  controller can accept; high only in IDLE.
- op_code  in  4  [3:2] unit (01 logic, 10 shifter, 11 add/sub, 00 illegal); [1:0] unit sub-function.
- operand_a, operand_b  in  16 each  operands.
- unit_a, unit_b  out  16 each  registered operands to the units.
- unit_func  out  2  registered op_code[1:0].
- logic_start, shift_start, add_sub_start  out  1 each  one-cycle start pulses.
- shift_done  in  1  shifter completion; the shifter result is valid in the same cycle.
- ar_mux_en  out  2  result-mux select: 01 logic, 10 shifter, 11 add/sub, 00 forces the mux output to 0.
- ar_mux_out  in  16  result-mux output.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  16  captured result.
- res_err  out  1  qualifies res_data: 1 for an illegal unit or a shifter timeout.
- busy  out  1  high in any state except IDLE.
- op_count  out  8  count of completed results handed off; wraps 255->0.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - op_ready=1.
  - On op_valid with a legal unit: register operands, unit_func and the unit code; go to ISSUE.
  - On op_valid with unit 00: res_data=0, res_err=1; go to DONE; no start pulse is issued.
- ISSUE (1 cycle)
  - The selected unit's start pulse is 1.
  - ar_mux_en = the registered unit code.
  - Go to WAIT.
  - The timeout counter clears to 0.
- WAIT
  - ar_mux_en is held at the unit code.
  - Logic or add/sub: lasts exactly 1 cycle. ar_mux_out is captured into res_data at the end of the cycle with res_err=0; go to DONE.
  - Shifter, shift_done=1: capture ar_mux_out with res_err=0; go to DONE.
  - Shifter, shift_done=0: increment the counter. If the counter reaches SHIFT_TIMEOUT, res_data=0 and res_err=1; go to DONE.
  - shift_done outside WAIT-for-shifter is ignored.
- DONE
  - res_valid=1; ar_mux_en=00; res_data and res_err are held stable.
  - On res_ready: op_count increments and the state returns to IDLE.
  - op_ready stays 0 throughout, so op_valid is ignored.
- The start pulse is one-hot. At most one start pulse is high in any cycle, and only in ISSUE.
- Reset mid-operation: the in-flight op is dropped without a result, no start pulse is issued on the reset cycle, and all outputs take their reset values at the next edge.

## Timing
- Reset values:
  - state = IDLE; op_ready = 1; busy = 0.
  - All start pulses = 0; ar_mux_en = 00.
  - res_valid = 0; res_data = 0; res_err = 0; op_count = 0.
  - unit_a, unit_b, unit_func = 0.
- All outputs are registered or decoded only from the state. No combinational path runs from any input to any output.
- Logic/add/sub latency, with the accept edge ending cycle T:
  - ISSUE in T+1.
  - WAIT in T+2, with capture at the end of T+2.
  - res_valid from T+3.
  - Best-case throughput: one op per 4 cycles when res_ready is held high.
- Shifter latency: if shift_done is first high in WAIT cycle k (k=1 is the first WAIT cycle), res_valid starts at T+2+k.
- Timeout: res_valid starts at T+2+SHIFT_TIMEOUT.
- Illegal op: res_valid starts at T+1.
- res_valid and res_data stay stable until the edge on which res_ready=1. op_ready rises in the following cycle.

## Test plan
- Add/sub: op_code=4'b1100, a=16'h0005, b=16'h0003, unit adds -> add_sub_start pulses at T+1; ar_mux_en=11 during T+1..T+2; res_data=16'h0008, res_err=0, res_valid at T+3; op_count 0->1 on handoff.
- Shifter, shift_done asserted on the 3rd WAIT cycle with ar_mux_out=16'h00F0 -> res_data=16'h00F0 at T+5; the timeout counter never fires.
- Shifter timeout, SHIFT_TIMEOUT=4, shift_done held 0 -> res_valid at T+6 with res_data=0 and res_err=1; a late shift_done arriving in DONE has no effect.
- Illegal op_code=4'b0010 -> no start pulses, ar_mux_en stays 00, res_valid=1 with res_err=1 and res_data=0 at T+1.
- Backpressure, res_ready=0 for 10 cycles then 1 -> res_data is stable throughout, op_ready=0, and op_valid is ignored. A second op is accepted the cycle after handoff.
- Reset: rst_n=0 during WAIT of a shift op -> all outputs at reset values next edge. Separately, 256 back-to-back ops -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencing controller for the 16-bit ALU result path
// One op in flight: IDLE -> ISSUE -> WAIT -> DONE, with the result held until handed off.
module alu_seq #(
  parameter int SHIFT_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_code,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  output logic [15:0] unit_a,
  output logic [15:0] unit_b,
  output logic [1:0]  unit_func,
  output logic        logic_start,
  output logic        shift_start,
  output logic        add_sub_start,
  input  logic        shift_done,
  output logic [1:0]  ar_mux_en,
  input  logic [15:0] ar_mux_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic        busy,
  output logic [7:0]  op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] U_NONE   = 2'b00;
  localparam logic [1:0] U_LOGIC  = 2'b01;
  localparam logic [1:0] U_SHIFT  = 2'b10;
  localparam logic [1:0] U_ADDSUB = 2'b11;

  localparam logic [7:0] TIMEOUT = 8'(SHIFT_TIMEOUT);

  logic [1:0] state;
  logic [1:0] unit;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  assign wait_cnt_nxt = wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      unit      <= U_NONE;
      wait_cnt  <= 8'd0;
      unit_a    <= 16'd0;
      unit_b    <= 16'd0;
      unit_func <= 2'd0;
      res_data  <= 16'd0;
      res_err   <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (op_code[3:2] == U_NONE) begin
              res_data <= 16'd0;
              res_err  <= 1'b1;
              state    <= DONE;
            end else begin
              unit_a    <= operand_a;
              unit_b    <= operand_b;
              unit_func <= op_code[1:0];
              unit      <= op_code[3:2];
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          // logic and add/sub settle in one cycle; only the shifter is waited on
          if (unit != U_SHIFT || shift_done) begin
            res_data <= ar_mux_out;
            res_err  <= 1'b0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt_nxt;
            if (wait_cnt_nxt == TIMEOUT) begin
              res_data <= 16'd0;
              res_err  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        default: begin
          if (res_ready) begin
            op_count <= op_count + 8'd1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  // every output below is a decode of registered state only
  assign op_ready      = (state == IDLE);
  assign busy          = (state != IDLE);
  assign res_valid     = (state == DONE);
  assign logic_start   = (state == ISSUE) && (unit == U_LOGIC);
  assign shift_start   = (state == ISSUE) && (unit == U_SHIFT);
  assign add_sub_start = (state == ISSUE) && (unit == U_ADDSUB);
  assign ar_mux_en     = (state == ISSUE || state == WAIT) ? unit : 2'b00;

endmodule
